// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/mux_21_dp.sv
// 2:1 datapath mux for valid/data/last, steered by the arbiter's select.
module mux_21_dp #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sel,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last
);

  always_comb begin
    y_valid = sel ? b_valid : a_valid;
    y_data  = sel ? b_data  : a_data;
    y_last  = sel ? b_last  : a_last;
  end

endmodule

// File: rtl/rr_mux_arbiter_21.sv
// Round-robin arbiter owning a 2:1 mux select; grant is locked per packet.
// Optional per-requester packet counters when RR_ARB_STATS_EN is defined.
module rr_mux_arbiter_21
  import rr_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter bit          START_B = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  input  logic              y_ready,
  output logic              sel,
  output logic              busy
`ifdef RR_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] cnt_a,
  output logic [STATS_W-1:0] cnt_b
`endif
);

  state_e state_q;
  logic   prio_q;  // requester favoured on the next contended arbitration
  logic   mux_valid;
  logic   mux_last;
  logic   a_done;
  logic   b_done;

  mux_21_dp #(
    .DATA_W(DATA_W)
  ) u_mux (
    .sel    (sel),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_last (a_last),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_last (b_last),
    .y_valid(mux_valid),
    .y_data (y_data),
    .y_last (mux_last)
  );

  always_comb begin
    y_valid = mux_valid & (state_q != IDLE);
    y_last  = mux_last  & (state_q != IDLE);
    a_ready = (state_q == GNT_A) & y_ready;
    b_ready = (state_q == GNT_B) & y_ready;
    a_done  = (state_q == GNT_A) & a_valid & y_ready & a_last;
    b_done  = (state_q == GNT_B) & b_valid & y_ready & b_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel     <= START_B;
      busy    <= 1'b0;
      prio_q  <= START_B;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_valid && (!b_valid || prio_q == SEL_A)) begin
            state_q <= GNT_A;
            sel     <= SEL_A;
            busy    <= 1'b1;
          end else if (b_valid) begin
            state_q <= GNT_B;
            sel     <= SEL_B;
            busy    <= 1'b1;
          end
        end
        GNT_A: begin
          if (a_done) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            prio_q  <= SEL_B;
          end
        end
        GNT_B: begin
          if (b_done) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            prio_q  <= SEL_A;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (a_done) cnt_a <= cnt_a + 1'b1;
      if (b_done) cnt_b <= cnt_b + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_21.sv
// Directed self-checking bench for rr_mux_arbiter_21 (stats checks need RR_ARB_STATS_EN).
module tb_rr_mux_arbiter_21;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, a_last, a_ready;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_last, b_ready;
  logic [DATA_W-1:0] b_data;
  logic              y_valid, y_last, y_ready;
  logic [DATA_W-1:0] y_data;
  logic              sel, busy;
`ifdef RR_ARB_STATS_EN
  logic [15:0]       cnt_a, cnt_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_21 #(
    .DATA_W (DATA_W),
    .START_B(1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_valid(a_valid),
    .a_data (a_data),
    .a_last (a_last),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_data (b_data),
    .b_last (b_last),
    .b_ready(b_ready),
    .y_valid(y_valid),
    .y_data (y_data),
    .y_last (y_last),
    .y_ready(y_ready),
    .sel    (sel),
    .busy   (busy)
`ifdef RR_ARB_STATS_EN
    ,
    .cnt_a  (cnt_a),
    .cnt_b  (cnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic l);
    a_valid = v; a_data = d; a_last = l;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic l);
    b_valid = v; b_data = d; b_last = l;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".y_valid"}, 32'(y_valid), 32'd0);
    check({tag, ".a_ready"}, 32'(a_ready), 32'd0);
    check({tag, ".b_ready"}, 32'(b_ready), 32'd0);
  endtask

`ifdef RR_ARB_STATS_EN
  // Single-beat packet from one requester, starting and ending in IDLE.
  task automatic send_one(input logic is_b, input logic [7:0] d);
    if (is_b) drive_b(1'b1, d, 1'b1);
    else      drive_a(1'b1, d, 1'b1);
    tick();
    tick();
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    y_ready = 1'b1;
    drive_a(1'b1, 8'h00, 1'b0);
    drive_b(1'b1, 8'h00, 1'b0);

    // Reset held two cycles with both requesters valid.
    tick(); settle();
    check("rst1.sel", 32'(sel), 32'd0);
    check_idle("rst1");
    tick(); settle();
    check("rst2.sel", 32'(sel), 32'd0);
    check_idle("rst2");
    rst = 1'b0;
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b0, 8'h00, 1'b0);
    tick();

    // Single requester, 3-beat packet.
    drive_a(1'b1, 8'h11, 1'b0); settle();
    check("a3.pre_valid", 32'(y_valid), 32'd0);
    tick(); settle();
    check("a3.busy",  32'(busy),    32'd1);
    check("a3.sel",   32'(sel),     32'd0);
    check("a3.d0",    32'(y_data),  32'h11);
    check("a3.l0",    32'(y_last),  32'd0);
    check("a3.ready", 32'(a_ready), 32'd1);
    tick(); drive_a(1'b1, 8'h22, 1'b0); settle();
    check("a3.d1", 32'(y_data), 32'h22);
    check("a3.l1", 32'(y_last), 32'd0);
    tick(); drive_a(1'b1, 8'h33, 1'b1); settle();
    check("a3.d2", 32'(y_data), 32'h33);
    check("a3.l2", 32'(y_last), 32'd1);
    tick(); drive_a(1'b0, 8'h00, 1'b0); settle();
    check_idle("a3.bubble");

    // Reset restores the pointer to favour A before the contention run.
    rst = 1'b1; tick(); rst = 1'b0;
    drive_a(1'b1, 8'hAA, 1'b1);
    drive_b(1'b1, 8'hBB, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick(); settle();
      check($sformatf("rr%0d.data", k), 32'(y_data), (k % 2 == 0) ? 32'hAA : 32'hBB);
      check($sformatf("rr%0d.sel", k),  32'(sel),    32'(k % 2));
      tick(); settle();
      check($sformatf("rr%0d.gap", k), 32'(y_valid), 32'd0);
    end

    // Grant lock under backpressure; pointer now favours A.
    drive_b(1'b0, 8'h00, 1'b0);
    drive_a(1'b1, 8'h5A, 1'b0);
    tick();
    y_ready = 1'b0;
    drive_b(1'b1, 8'hCC, 1'b1);
    settle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lock%0d.sel", k),     32'(sel),     32'd0);
      check($sformatf("lock%0d.b_ready", k), 32'(b_ready), 32'd0);
      check($sformatf("lock%0d.a_ready", k), 32'(a_ready), 32'd0);
      check($sformatf("lock%0d.data", k),    32'(y_data),  32'h5A);
      tick(); settle();
    end
    y_ready = 1'b1;
    tick(); drive_a(1'b1, 8'h6B, 1'b1); settle();
    check("lock.last_data", 32'(y_data), 32'h6B);
    tick(); drive_a(1'b0, 8'h00, 1'b0); settle();
    check("lock.bubble", 32'(busy), 32'd0);
    tick(); settle();
    check("lock.b_sel",   32'(sel),     32'd1);
    check("lock.b_data",  32'(y_data),  32'hCC);
    check("lock.b_ready", 32'(b_ready), 32'd1);
    check("lock.a_ready", 32'(a_ready), 32'd0);
    tick(); drive_b(1'b0, 8'h00, 1'b0);

    // Reset during beat 2 of a 4-beat B packet.
    drive_b(1'b1, 8'h01, 1'b0);
    tick(); settle();
    check("rstmid.grant", 32'(sel), 32'd1);
    tick(); drive_b(1'b1, 8'h02, 1'b0); settle();
    check("rstmid.beat2", 32'(y_data), 32'h02);
    rst = 1'b1;
    tick(); rst = 1'b0; settle();
    check("rstmid.sel", 32'(sel), 32'd0);
    check_idle("rstmid");
    drive_b(1'b0, 8'h00, 1'b0);
    tick(); settle();
    check_idle("rstmid.after");

`ifdef RR_ARB_STATS_EN
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) send_one(1'b0, 8'h10);
    for (int k = 0; k < 3; k++) send_one(1'b1, 8'h20);
    settle();
    check("stats.cnt_a", 32'(cnt_a), 32'd5);
    check("stats.cnt_b", 32'(cnt_b), 32'd3);
    force dut.cnt_a = 16'hFFFF;
    tick();
    release dut.cnt_a;
    send_one(1'b0, 8'h30);
    settle();
    check("stats.wrap", 32'(cnt_a), 32'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so a broken DUT cannot hang the run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
